alu_share_arb: RTL and testbench
================================

ALU_SHARE_ARB -- requirements
Module: alu_share_arb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width.
REQ-002 SHALL have parameter FUN_W, default 6, ALUFun code width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  2  per-requester request valid (bit0 = port 0, bit1 = port 1).
REQ-006 SHALL have port req_ready  output  2  per-requester request accepted.
REQ-007 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  DATA_W  operands A/B per requester.
REQ-008 SHALL have ports req0_fun, req1_fun  input  FUN_W  ALUFun code per requester.
REQ-009 SHALL have ports req0_sign, req1_sign  input  1  Sign flag per requester.
REQ-010 SHALL have port rsp_valid  output  2  result valid, only the granted bit may be high.
REQ-011 SHALL have port rsp_ready  input  2  per-requester result consumed.
REQ-012 SHALL have port rsp_z  output  DATA_W  registered ALU result Z, shared by both requesters.

Function
REQ-013 SHALL run a three-state FSM: IDLE, EXEC, RESP.
REQ-014 IDLE: no request valid -> stay IDLE; req_ready = 00.
REQ-015 IDLE with valid requests: grant one requester combinationally, assert only its req_ready bit the same cycle, latch its A/B/fun/sign and grant index on the edge, go EXEC.
REQ-016 Both requests valid in IDLE: grant the port named by a 1-bit round-robin pointer; single valid request: grant it regardless of pointer.
REQ-017 EXEC: drive latched operands into one ALU instance; capture Z into rsp_z on the edge; go RESP; req_ready = 00.
REQ-018 RESP: assert rsp_valid for the granted port only; hold rsp_z stable; req_ready = 00.
REQ-019 RESP with rsp_ready on the granted bit: go IDLE on that edge and set the pointer to the other port; rsp_ready on the non-granted bit SHALL be ignored.
REQ-020 Latency: request accepted at edge N -> rsp_valid high in the cycle after edge N+1; minimum three cycles per operation, no overlap.
REQ-021 Requester dropping req_valid before acceptance SHALL cause no state change; operand changes after acceptance SHALL not affect the result.
REQ-022 rsp_z SHALL be exactly the ALU's Z for the latched operands (all 32 bits, no truncation or extension).

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, pointer = 0 (port 0 preferred), req_ready = 00, rsp_valid = 00, rsp_z = 0, latched operands = 0.
REQ-024 Reset during EXEC or RESP SHALL abort the operation silently; no response is ever issued for it.

Configuration
REQ-025 Macro ALU_ARB_PERF_EN defined: SHALL add outputs grant_cnt0, grant_cnt1 (output 16 each), incremented on each acceptance for that port, wrapping FFFF->0000, cleared by reset.
REQ-026 Macro ALU_ARB_PERF_EN undefined: those ports and counters SHALL not exist; all other behaviour is identical.

Structure
REQ-027 A shared package SHALL hold the state enumeration (IDLE/EXEC/RESP), the DATA_W/FUN_W defaults, and the ALUFun code constants (ADD 000000, AND 011000, SLL 100000, EQ 110011).
REQ-028 The sole sub-module SHALL be the existing ALU (ports A, B, ALUFun, Sign, Z), instantiated once; arbitration and the FSM stay in alu_share_arb.

Verification
REQ-029 Port0 only: A=00000001, B=FFFFFFFF, fun=000000, sign=0 -> rsp_valid=01 two cycles after acceptance, rsp_z=00000000.
REQ-030 Both valid after reset: port0 fun=011000, port1 fun=100000, A=00000001, B=FFFFFFFF -> port0 served first, rsp_z=00000001; then port1, rsp_z=FFFFFFFE.
REQ-031 Both valid continuously for 4 operations -> grants alternate 0,1,0,1; req_ready is never 11.
REQ-032 Port1 with fun=110011, A=5, B=5, rsp_ready held low 5 cycles -> rsp_valid=10 and rsp_z=00000001 stable throughout, no new grant until rsp_ready[1]=1.
REQ-033 rst_n pulsed low during EXEC -> outputs zero immediately, no rsp_valid afterwards, next request served from port 0 with priority.
REQ-034 ALU_ARB_PERF_EN defined, grant_cnt0 preloaded to FFFF via 65535 port0 grants -> one more grant gives grant_cnt0=0000, grant_cnt1 unchanged.

Source files
------------

// File: rtl/alu_share_arb_pkg.sv
// alu_share_arb_pkg: shared FSM state codes, width defaults and ALUFun encodings
package alu_share_arb_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int FUN_W_DEF  = 6;
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t EXEC = 2'd1;
    localparam state_t RESP = 2'd2;
    localparam logic [5:0] FUN_ADD = 6'b000000;
    localparam logic [5:0] FUN_AND = 6'b011000;
    localparam logic [5:0] FUN_SLL = 6'b100000;
    localparam logic [5:0] FUN_EQ  = 6'b110011;
endpackage

// File: rtl/alu_share_arb_alu.sv
// alu_share_arb_alu: combinational ALU (arith, logic, shift, compare groups selected by ALUFun[5:4])
module alu_share_arb_alu
    import alu_share_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FUN_W  = FUN_W_DEF
) (
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [FUN_W-1:0]  ALUFun,
    input  logic              Sign,
    output logic [DATA_W-1:0] Z
);
    localparam int SH_W = $clog2(DATA_W);
    localparam logic [1:0] GRP_ARITH = FUN_ADD[5:4];
    localparam logic [1:0] GRP_LOGIC = FUN_AND[5:4];
    localparam logic [1:0] GRP_SHIFT = FUN_SLL[5:4];
    logic [DATA_W-1:0] sum, lgc, shf, sra;
    logic [SH_W-1:0] sh;
    logic lt, flag;
    // compute each group's result, then pick the group named by ALUFun[5:4]
    always_comb begin
        sum  = A + (ALUFun[0] ? ~B : B) + {{(DATA_W-1){1'b0}}, ALUFun[0]};
        lgc  = (ALUFun[3:0] == FUN_AND[3:0]) ? (A & B)
             : (ALUFun[3:0] == 4'b1110) ? (A | B)
             : (ALUFun[3:0] == 4'b0110) ? (A ^ B)
             : (ALUFun[3:0] == 4'b0001) ? ~(A | B)
             : A;
        sh   = A[SH_W-1:0];
        sra  = $signed(B) >>> sh;
        shf  = (ALUFun[1:0] == FUN_SLL[1:0]) ? (B << sh) : ALUFun[1] ? sra : (B >> sh);
        lt   = Sign ? ($signed(A) < $signed(B)) : (A < B);
        flag = (ALUFun[3:1] == FUN_EQ[3:1]) ? (A == B)
             : (ALUFun[3:1] == 3'b000) ? (A != B)
             : (ALUFun[3:1] == 3'b010) ? lt
             : (ALUFun[3:1] == 3'b110) ? (A[DATA_W-1] | ~|A)
             : (ALUFun[3:1] == 3'b101) ? A[DATA_W-1]
             : (ALUFun[3:1] == 3'b111) ? (~A[DATA_W-1] & |A)
             : 1'b0;
        Z    = (ALUFun[5:4] == GRP_ARITH) ? sum
             : (ALUFun[5:4] == GRP_LOGIC) ? lgc
             : (ALUFun[5:4] == GRP_SHIFT) ? shf
             : {{(DATA_W-1){1'b0}}, flag};
    end
endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: two requesters share one ALU via a round-robin IDLE/EXEC/RESP FSM; ALU_ARB_PERF_EN adds grant counters
module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FUN_W  = FUN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [FUN_W-1:0]  req0_fun,
    input  logic [FUN_W-1:0]  req1_fun,
    input  logic              req0_sign,
    input  logic              req1_sign,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [DATA_W-1:0] rsp_z
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [15:0]       grant_cnt0,
    output logic [15:0]       grant_cnt1
`endif
);
    state_t state;
    logic ptr, gnt, sel, accept, sign_q;
    logic [DATA_W-1:0] a_q, b_q, z;
    logic [FUN_W-1:0] fun_q;

    alu_share_arb_alu #(.DATA_W(DATA_W), .FUN_W(FUN_W)) u_alu (
        .A(a_q), .B(b_q), .ALUFun(fun_q), .Sign(sign_q), .Z(z)
    );

    // grant: pointer breaks a tie, a lone request wins regardless; handshakes only in IDLE
    always_comb begin
        sel       = (req_valid == 2'b11) ? ptr : req_valid[1];
        accept    = rst_n && (state == IDLE) && (req_valid != 2'b00);
        req_ready = accept ? (sel ? 2'b10 : 2'b01) : 2'b00;
        rsp_valid = (state == RESP) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    end

    // latch the winner on accept, capture Z in EXEC, hand off the pointer when the winner consumes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= 1'b0;
            gnt    <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            fun_q  <= '0;
            sign_q <= 1'b0;
            rsp_z  <= '0;
        end else if (accept) begin
            state  <= EXEC;
            gnt    <= sel;
            a_q    <= sel ? req1_a : req0_a;
            b_q    <= sel ? req1_b : req0_b;
            fun_q  <= sel ? req1_fun : req0_fun;
            sign_q <= sel ? req1_sign : req0_sign;
        end else if (state == EXEC) begin
            state  <= RESP;
            rsp_z  <= z;
        end else if ((state == RESP) && rsp_ready[gnt]) begin
            state  <= IDLE;
            ptr    <= ~gnt;
        end
    end

`ifdef ALU_ARB_PERF_EN
    // per-port acceptance counters, wrapping at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (accept && sel) begin
            grant_cnt1 <= grant_cnt1 + 16'd1;
        end else if (accept) begin
            grant_cnt0 <= grant_cnt0 + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed self-checking bench for alu_share_arb
module tb_alu_share_arb;
    import alu_share_arb_pkg::*;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [5:0]  req0_fun = '0, req1_fun = '0;
    logic        req0_sign = 1'b0, req1_sign = 1'b0;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = 2'b00;
    logic [31:0] rsp_z;
    int n_chk = 0, n_pass = 0, g0 = 0, g1 = 0;
`ifdef ALU_ARB_PERF_EN
    logic [15:0] grant_cnt0, grant_cnt1;
`endif

    alu_share_arb dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_fun(req0_fun), .req1_fun(req1_fun),
        .req0_sign(req0_sign), .req1_sign(req1_sign),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_z(rsp_z)
`ifdef ALU_ARB_PERF_EN
        , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog: bench did not finish, checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one full operation for the expected winner g; hold = extra RESP cycles with rsp_ready withheld
    task automatic run_op(input logic [1:0] vld, input logic g, input logic [31:0] ez, input int hold, input bit keep);
        logic [1:0] oh;
        oh = g ? 2'b10 : 2'b01;
        req_valid = vld;
        #1;
        check("accept_ready", {30'd0, req_ready}, {30'd0, oh});
        check("accept_novalid", {30'd0, rsp_valid}, 32'd0);
        tick();
        if (g) g1++; else g0++;
        if (!keep) begin
            req_valid = 2'b00;
            req0_a = ~req0_a;
            req0_b = ~req0_b;
            req1_a = ~req1_a;
            req1_b = ~req1_b;
        end
        #1;
        check("exec_ready", {30'd0, req_ready}, 32'd0);
        check("exec_valid", {30'd0, rsp_valid}, 32'd0);
        tick();
        check("rsp_valid", {30'd0, rsp_valid}, {30'd0, oh});
        check("rsp_z", rsp_z, ez);
        for (int i = 0; i < hold; i++) begin
            req_valid = 2'b11;
            rsp_ready = ~oh;
            tick();
            check("hold_valid", {30'd0, rsp_valid}, {30'd0, oh});
            check("hold_z", rsp_z, ez);
            check("hold_ready", {30'd0, req_ready}, 32'd0);
        end
        req_valid = keep ? vld : 2'b00;
        rsp_ready = oh;
        tick();
        rsp_ready = 2'b00;
    endtask

    initial begin
        req_valid = 2'b11;
        #12;
        check("reset_ready", {30'd0, req_ready}, 32'd0);
        check("reset_valid", {30'd0, rsp_valid}, 32'd0);
        check("reset_z", rsp_z, 32'd0);
        req_valid = 2'b00;
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_ready", {30'd0, req_ready}, 32'd0);
        // both valid after reset: port 0 first (AND), then port 1 (SLL)
        req0_a = 32'h1; req0_b = 32'hFFFFFFFF; req0_fun = FUN_AND;
        req1_a = 32'h1; req1_b = 32'hFFFFFFFF; req1_fun = FUN_SLL;
        run_op(2'b11, 1'b0, 32'h00000001, 0, 1'b1);
        req1_a = 32'h1; req1_b = 32'hFFFFFFFF;
        run_op(2'b10, 1'b1, 32'hFFFFFFFE, 0, 1'b0);
        // port 0 alone: ADD with wraparound; operands scrambled after accept
        req0_a = 32'h1; req0_b = 32'hFFFFFFFF; req0_fun = FUN_ADD; req0_sign = 1'b0;
        run_op(2'b01, 1'b0, 32'h00000000, 0, 1'b0);
        // port 1 EQ with consumer stalled 5 cycles
        req1_a = 32'd5; req1_b = 32'd5; req1_fun = FUN_EQ;
        req0_a = 32'd1; req0_b = 32'd2; req0_fun = FUN_ADD;
        run_op(2'b10, 1'b1, 32'h00000001, 5, 1'b0);
        // continuous contention: grants alternate 0,1,0,1
        req0_a = 32'd2; req0_b = 32'd3; req0_fun = FUN_ADD;
        req1_a = 32'd6; req1_b = 32'd3; req1_fun = FUN_AND;
        for (int k = 0; k < 4; k++)
            run_op(2'b11, k[0], k[0] ? 32'd2 : 32'd5, 0, 1'b1);
        req_valid = 2'b00;
        // port 0 op leaves the pointer on port 1
        req0_a = 32'd3; req0_b = 32'd4; req0_fun = FUN_ADD;
        run_op(2'b01, 1'b0, 32'd7, 0, 1'b0);
        // abort a port 1 op in EXEC
        req1_a = 32'd9; req1_b = 32'd9; req1_fun = FUN_EQ;
        req_valid = 2'b10;
        #1;
        check("abort_accept", {30'd0, req_ready}, 32'h2);
        tick();
        req_valid = 2'b00;
        rst_n = 1'b0;
        #1;
        check("abort_z", rsp_z, 32'd0);
        check("abort_valid", {30'd0, rsp_valid}, 32'd0);
        check("abort_ready", {30'd0, req_ready}, 32'd0);
        tick();
        rst_n = 1'b1;
        g0 = 0;
        g1 = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("abort_quiet", {30'd0, rsp_valid}, 32'd0);
        end
        req0_a = 32'd10; req0_b = 32'd20; req0_fun = FUN_ADD;
        req1_a = 32'hF; req1_b = 32'hF; req1_fun = FUN_AND;
        run_op(2'b11, 1'b0, 32'd30, 0, 1'b0);
`ifdef ALU_ARB_PERF_EN
        check("grant_cnt0", {16'd0, grant_cnt0}, g0);
        check("grant_cnt1", {16'd0, grant_cnt1}, g1);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
